oh_iddr_deser: RTL and testbench

Dual data rate receive deserializer: the input-side counterpart of the DDR output buffer. Captures a single-pin DDR bit stream (bit during clk high, then bit during clk low, each cycle), reassembles it into DW-bit words, finds word alignment by hunting for a sync pattern at either bit phase, and emits aligned words with a valid strobe once locked. Sits directly behind the input pad in link/PHY receive paths.

---
 rtl/oh_iddr_deser_if.sv | 13 +
 rtl/oh_iddr_deser.sv | 89 ++++++++
 tb/tb_oh_iddr_deser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/oh_iddr_deser_if.sv
// oh_iddr_deser_if: serial input, control and aligned word output bundle of the DDR deserializer
`timescale 1ns/1ps
interface oh_iddr_deser_if #(parameter int DW = 8);
  logic in;
  logic relock;
  logic [DW-1:0] out;
  logic valid;
  logic locked;
  logic phase;
  logic err;
  modport master (output in, relock, input out, valid, locked, phase, err);
  modport slave (input in, relock, output out, valid, locked, phase, err);
endinterface

// File: rtl/oh_iddr_deser.sv
// oh_iddr_deser: DDR receive deserializer with sync-pattern word alignment at either bit phase
`timescale 1ns/1ps
module oh_iddr_deser #(
  parameter int DW = 8,
  parameter logic [DW-1:0] SYNC = DW'(8'hA5),
  parameter int LOCK_CNT = 2,
  parameter PROP = "DEFAULT"
) (
  input logic clk,
  input logic reset,
  oh_iddr_deser_if.slave bus
);
  localparam int BW = $clog2(DW/2);
  localparam int CW = $clog2(LOCK_CNT+1);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  logic neg;
  logic [1:0] pair;
  logic [DW:0] sr;
  logic [1:0] state;
  logic [BW-1:0] beat;
  logic [CW-1:0] cnt;
  logic [DW-1:0] even_w, odd_w, win;
  logic even_hit, odd_hit, wrap;
  if (PROP != "DEFAULT") begin : g_prop
  end
  assign even_w = sr[DW:1];
  assign odd_w = sr[DW-1:0];
  assign win = bus.phase ? odd_w : even_w;
  assign even_hit = even_w == SYNC;
  assign odd_hit = odd_w == SYNC;
  assign wrap = beat == BW'(DW/2-1);
  assign bus.locked = state == LOCKED;
  always_ff @(negedge clk)
    neg <= bus.in;
  always_ff @(posedge clk) begin
    if (reset) begin
      pair <= '0;
      sr <= '0;
      state <= HUNT;
      beat <= '0;
      cnt <= '0;
      bus.out <= '0;
      bus.valid <= 1'b0;
      bus.phase <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      pair <= {bus.in, neg};
      sr <= {pair, sr[DW:2]};
      bus.valid <= 1'b0;
      bus.err <= 1'b0;
      beat <= wrap ? '0 : beat + 1'b1;
      if (bus.relock) begin
        state <= HUNT;
        beat <= '0;
        cnt <= '0;
      end else begin
        case (state)
          HUNT: begin
            beat <= '0;
            if (even_hit || odd_hit) begin
              bus.phase <= !even_hit;
              cnt <= CW'(1);
              state <= (LOCK_CNT == 1) ? LOCKED : CHECK;
            end
          end
          CHECK: begin
            if (wrap && win == SYNC) begin
              cnt <= cnt + 1'b1;
              state <= ((cnt + 1'b1) == CW'(LOCK_CNT)) ? LOCKED : CHECK;
            end else if (wrap) begin
              bus.err <= 1'b1;
              state <= HUNT;
              cnt <= '0;
            end
          end
          LOCKED: begin
            if (wrap) begin
              bus.out <= win;
              bus.valid <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oh_iddr_deser.sv
// tb_oh_iddr_deser: directed DDR bit streams with a scoreboard of expected words, errors and cycles
`timescale 1ns/1ps
module tb_oh_iddr_deser;
  typedef struct { bit b; bit v; bit e; bit m; logic [7:0] w; } bit_t;
  typedef struct { logic [7:0] w; int c; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int mark_cyc = 0;
  bit mark_seen = 1'b0;
  bit rnd = 1'b0;
  bit_t txq[$];
  exp_t exp_v[$];
  int exp_e[$];
  oh_iddr_deser_if #(.DW(8)) bus();
  oh_iddr_deser #(.DW(8), .SYNC(8'hA5), .LOCK_CNT(2), .PROP("DEFAULT")) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic drive();
    bit_t t;
    if (txq.size() == 0) begin
      bus.in = rnd ? 1'($urandom) : 1'b0;
      return;
    end
    t = txq.pop_front();
    bus.in = t.b;
    if (t.v) exp_v.push_back('{t.w, cyc + 3});
    if (t.e) exp_e.push_back(cyc + 3);
    if (t.m) begin
      mark_cyc = cyc;
      mark_seen = 1'b1;
    end
  endtask
  task automatic push_word(logic [7:0] w, bit v = 1'b0, bit e = 1'b0, bit m = 1'b0);
    for (int i = 0; i < 8; i++) txq.push_back('{w[i], (i == 7) && v, (i == 7) && e, (i == 7) && m, w});
  endtask
  task automatic push_bit(bit b);
    txq.push_back('{b, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask
  task automatic align();
    @(negedge clk);
    #2;
  endtask
  task automatic wait_idle(int budget);
    int b = budget;
    while ((txq.size() + exp_v.size() + exp_e.size()) != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    chk("drain", txq.size() + exp_v.size() + exp_e.size(), 0);
  endtask
  task automatic wait_mark(int offset);
    int b = 300;
    while (!mark_seen && b > 0) begin
      @(posedge clk);
      #1;
      b--;
    end
    chk("mark reached", mark_seen, 1);
    while (cyc < mark_cyc + offset && b > 0) begin
      @(posedge clk);
      #1;
      b--;
    end
    mark_seen = 1'b0;
  endtask
  task automatic relock_at_mark(bit ph);
    wait_mark(2);
    chk("locked before relock", bus.locked, 1);
    chk("phase", bus.phase, ph);
    bus.relock = 1'b1;
    @(posedge clk);
    #1;
    bus.relock = 1'b0;
    #2;
    chk("locked after relock", bus.locked, 0);
    chk("valid on relock", bus.valid, 0);
    chk("phase held", bus.phase, ph);
  endtask
  task automatic chk_cleared(string n);
    chk({n, " out"}, bus.out, 0);
    chk({n, " valid"}, bus.valid, 0);
    chk({n, " locked"}, bus.locked, 0);
    chk({n, " phase"}, bus.phase, 0);
    chk({n, " err"}, bus.err, 0);
  endtask
  initial begin
    bus.in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      #1;
      drive();
    end
  end
  always @(negedge clk) begin : mon
    exp_t e;
    while (exp_v.size() > 0 && exp_v[0].c < cyc) begin
      chk("missed valid", 0, {24'h0, exp_v[0].w});
      void'(exp_v.pop_front());
    end
    while (exp_e.size() > 0 && exp_e[0] < cyc) begin
      chk("missed err", bus.err, 1);
      void'(exp_e.pop_front());
    end
    if (bus.valid) begin
      if (exp_v.size() == 0) chk("unexpected valid", bus.valid, 0);
      else begin
        e = exp_v.pop_front();
        chk("out", bus.out, e.w);
        chk("valid cycle", cyc, e.c);
      end
    end
    if (bus.err) begin
      chk("err with valid", bus.valid, 0);
      if (exp_e.size() == 0) chk("unexpected err", bus.err, 0);
      else chk("err cycle", cyc, exp_e.pop_front());
    end
  end
  initial begin
    bus.relock = 1'b0;
    rnd = 1'b1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #3;
      chk_cleared("in reset");
    end
    reset = 1'b0;
    rnd = 1'b0;
    @(posedge clk);
    #3;
    chk_cleared("after reset");
    repeat (4) @(posedge clk);
    align();
    push_word(8'h00);
    push_word(8'hA5);
    push_word(8'hA5);
    push_word(8'h3C, 1'b1);
    push_word(8'h81, 1'b1);
    push_word(8'h00, 1'b0, 1'b0, 1'b1);
    relock_at_mark(1'b0);
    wait_idle(100);
    align();
    push_word(8'hA5);
    push_word(8'hA5);
    push_word(8'hC3, 1'b1, 1'b0, 1'b1);
    push_word(8'h00);
    push_word(8'h00);
    wait_mark(4);
    chk("relocked", bus.locked, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk_cleared("mid reset");
    wait_idle(100);
    repeat (20) @(posedge clk);
    align();
    push_word(8'h00);
    push_bit(1'b1);
    push_word(8'hA5);
    push_word(8'hA5);
    push_word(8'h3C, 1'b1);
    push_word(8'h81, 1'b1);
    push_word(8'h00, 1'b0, 1'b0, 1'b1);
    relock_at_mark(1'b1);
    wait_idle(100);
    align();
    push_word(8'h00);
    push_word(8'hA5);
    push_word(8'h5A, 1'b0, 1'b1);
    push_word(8'h00);
    wait_idle(100);
    chk("locked after err", bus.locked, 0);
    align();
    push_word(8'hA5);
    push_word(8'hA5);
    push_word(8'h77, 1'b1);
    push_word(8'h00, 1'b0, 1'b0, 1'b1);
    relock_at_mark(1'b0);
    wait_idle(100);
    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
